regfile_mp: RTL

- Parametrised multi-port integer register file for the next-generation pipelined core.
- Provides NUM_RD combinational read ports and two synchronous write ports: A for ALU/early writeback, B for load/late writeback.
- Contains a per-register pending-write scoreboard that issue sets and writeback clears. Decode uses it for RAW hazard stalls.
- Sits between decode (reads, issue) and writeback (writes).

---
 rtl/regfile_mp.sv | 116 +++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NUM_RD combinational reads, two write ports (B beats A),
// and a pending-write scoreboard with a registered pending count. `REGFILE_BYPASS_EN adds
// same-cycle write forwarding on the read ports.
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       wa_en_i,
    input  logic [ADDR_W-1:0]          wa_addr_i,
    input  logic [DATA_W-1:0]          wa_data_i,
    input  logic                       wb_en_i,
    input  logic [ADDR_W-1:0]          wb_addr_i,
    input  logic [DATA_W-1:0]          wb_data_i,
    input  logic                       iss_en_i,
    input  logic [ADDR_W-1:0]          iss_addr_i,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
    output logic [NUM_RD-1:0]          rd_busy_o,
    output logic [ADDR_W:0]            pend_cnt_o
);

    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam int unsigned CntW  = ADDR_W + 1;

    logic [DATA_W-1:0] mem_q [Depth];
    logic [DATA_W-1:0] mem_d [Depth];
    logic [Depth-1:0]  pend_q, pend_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    // Enables qualified so that address 0 is untouchable when it is the zero register.
    logic wa_we, wb_we, iss_we;
    assign wa_we  = wa_en_i  && !(ZERO_REG && (wa_addr_i  == '0));
    assign wb_we  = wb_en_i  && !(ZERO_REG && (wb_addr_i  == '0));
    assign iss_we = iss_en_i && !(ZERO_REG && (iss_addr_i == '0));

    // B is applied last so it wins an address collision with A.
    always_comb begin
        mem_d = mem_q;
        if (wa_we) begin
            mem_d[wa_addr_i] = wa_data_i;
        end
        if (wb_we) begin
            mem_d[wb_addr_i] = wb_data_i;
        end
    end

    // Issue beats writeback: a new producer keeps the register pending.
    always_comb begin
        pend_d = pend_q;
        for (int unsigned r = 0; r < Depth; r++) begin
            if (iss_we && (iss_addr_i == ADDR_W'(r))) begin
                pend_d[r] = 1'b1;
            end else if ((wa_we && (wa_addr_i == ADDR_W'(r))) ||
                         (wb_we && (wb_addr_i == ADDR_W'(r)))) begin
                pend_d[r] = 1'b0;
            end
        end
    end

    always_comb begin
        cnt_d = '0;
        for (int unsigned r = 0; r < Depth; r++) begin
            cnt_d = cnt_d + CntW'(pend_d[r]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned r = 0; r < Depth; r++) begin
                mem_q[r] <= '0;
            end
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pend_cnt_o = cnt_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0] rd_data;
        logic              rd_busy;

        assign rd_addr = rd_addr_i[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd_data = mem_q[rd_addr];
            rd_busy = pend_q[rd_addr];
`ifdef REGFILE_BYPASS_EN
            if (wb_we && (wb_addr_i == rd_addr)) begin
                rd_data = wb_data_i;
                rd_busy = iss_we && (iss_addr_i == rd_addr);
            end else if (wa_we && (wa_addr_i == rd_addr)) begin
                rd_data = wa_data_i;
                rd_busy = iss_we && (iss_addr_i == rd_addr);
            end
`endif
            if (ZERO_REG && (rd_addr == '0)) begin
                rd_data = '0;
                rd_busy = 1'b0;
            end
        end

        assign rd_data_o[k*DATA_W +: DATA_W] = rd_data;
        assign rd_busy_o[k]                  = rd_busy;
    end

endmodule
